// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared types for the 9-bit ISA control stage
package ctrl_pkg;

   typedef enum logic [2:0] {
      LDST  = 3'd0,
      MOV   = 3'd1,
      ALU   = 3'd2,
      SHIFT = 3'd3,
      JMP   = 3'd4,
      BLT   = 3'd5,
      BEQ   = 3'd6,
      IMM   = 3'd7
   } opcode_e;

   localparam logic [3:0] ALU_ADD   = 4'd0;
   localparam logic [3:0] ALU_SUB   = 4'd1;
   localparam logic [3:0] ALU_AND   = 4'd2;
   localparam logic [3:0] ALU_INC   = 4'd3;
   localparam logic [3:0] ALU_NOT   = 4'd4;
   localparam logic [3:0] ALU_NEG   = 4'd5;
   localparam logic [3:0] ALU_BLT   = 4'd6;
   localparam logic [3:0] ALU_BEQ   = 4'd7;
   localparam logic [3:0] ALU_MOV   = 4'd8;
   localparam logic [3:0] ALU_SHIFT = 4'd9;
   localparam logic [3:0] ALU_ADDI  = 4'd10;
   localparam logic [3:0] ALU_SUBI  = 4'd11;
   localparam logic [3:0] ALU_JMP   = 4'd12;

   // Register fields are kept at their native 3 bits; the top zero-extends them.
   typedef struct packed {
      logic [3:0] Aluop;
      logic [4:0] Jptr;
      logic [2:0] Ra;
      logic [2:0] Rb;
      logic [2:0] Wd;
      logic [2:0] Imm;
      logic       WenR;
      logic       WenD;
      logic       Ldr;
      logic       Str;
   } ctrl_t;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_MEM   = 2'd1,
      ST_FLUSH = 2'd2
   } state_e;

endpackage

// File: rtl/ctrl_decode.sv
// rtl/ctrl_decode.sv - combinational instruction decoder, mach_code to ctrl_t
module ctrl_decode
   import ctrl_pkg::*;
(
   input  logic [8:0] mach_code,
   output ctrl_t      ctrl,
   output logic       is_ldst,
   output logic       is_jmp,
   output logic       is_br
);

   opcode_e    op;
   logic [5:0] b;

   assign op = opcode_e'(mach_code[8:6]);
   assign b  = mach_code[5:0];

   always_comb begin
      ctrl    = '0;
      is_ldst = 1'b0;
      is_jmp  = 1'b0;
      is_br   = 1'b0;
      case (op)
         LDST: begin
            is_ldst = 1'b1;
            if (!b[5]) begin
               ctrl.Ldr  = 1'b1;
               ctrl.Wd   = b[4:2];
               ctrl.Rb   = {1'b0, b[1:0]};
               ctrl.WenR = 1'b1;
            end else begin
               ctrl.Str  = 1'b1;
               ctrl.Ra   = {1'b0, b[4:3]};
               ctrl.Rb   = b[2:0];
               ctrl.WenD = 1'b1;
            end
         end
         MOV: begin
            ctrl.Ra    = b[5:3];
            ctrl.Rb    = b[2:0];
            ctrl.Wd    = b[2:0];
            ctrl.Aluop = ALU_MOV;
            ctrl.WenR  = 1'b1;
         end
         ALU: begin
            ctrl.Rb   = {1'b0, b[1:0]};
            ctrl.WenR = 1'b1;
            // Function code 11 selects the single-operand group keyed by b[3:2].
            if (b[5:4] == 2'b11) begin
               ctrl.Ra = {1'b0, b[1:0]};
               ctrl.Wd = {1'b0, b[1:0]};
               case (b[3:2])
                  2'b10:   ctrl.Aluop = ALU_NOT;
                  2'b01:   ctrl.Aluop = ALU_NEG;
                  default: ctrl.Aluop = ALU_INC;
               endcase
            end else begin
               ctrl.Ra    = {1'b0, b[3:2]};
               ctrl.Wd    = {1'b0, b[3:2]};
               ctrl.Aluop = {2'b00, b[5:4]};
            end
         end
         SHIFT: begin
            ctrl.Ra    = b[5:3];
            ctrl.Wd    = b[5:3];
            ctrl.Imm   = b[2:0];
            ctrl.Aluop = ALU_SHIFT;
            ctrl.WenR  = 1'b1;
         end
         JMP: begin
            if (b[5]) begin
               is_jmp     = 1'b1;
               ctrl.Jptr  = b[4:0];
               ctrl.Aluop = ALU_JMP;
            end else begin
               ctrl.Ra    = {1'b0, b[3:2]};
               ctrl.Wd    = {1'b0, b[3:2]};
               ctrl.Rb    = {1'b0, b[1:0]};
               ctrl.Aluop = ALU_SUB;
            end
         end
         BLT, BEQ: begin
            is_br      = 1'b1;
            ctrl.Ra    = b[5:3];
            ctrl.Rb    = b[2:0];
            ctrl.Aluop = (op == BLT) ? ALU_BLT : ALU_BEQ;
         end
         IMM: begin
            ctrl.Aluop = {3'b101, b[5]};
            ctrl.Ra    = {1'b0, b[4:3]};
            ctrl.Wd    = {1'b0, b[4:3]};
            ctrl.Imm   = b[2:0];
            ctrl.WenR  = 1'b1;
         end
         default: ctrl = '0;
      endcase
   end

endmodule

// File: rtl/ctrl_pipe.sv
// rtl/ctrl_pipe.sv - registered control stage with memory hold and wrong-path squash
module ctrl_pipe
   import ctrl_pkg::*;
#(
   parameter int MEM_LAT   = 2,
   parameter int FLUSH_CYC = 2,
   parameter int RW        = 3
) (
   input  logic          Clk,
   input  logic          Reset,
   input  logic [8:0]    mach_code,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic          br_taken,
   output logic [3:0]    Aluop,
   output logic [4:0]    Jptr,
   output logic [RW-1:0] Ra,
   output logic [RW-1:0] Rb,
   output logic [RW-1:0] Wd,
   output logic [2:0]    Imm,
   output logic          WenR,
   output logic          WenD,
   output logic          Ldr,
   output logic          Str,
   output logic          out_valid,
   output logic          out_is_br,
   output logic          redirect
);

   localparam int MW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
   localparam int FW = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
   localparam logic [MW-1:0] MEM_LAST   = MW'(MEM_LAT - 1);
   localparam logic [MW-1:0] MEM_PRE    = MW'(MEM_LAT - 2);
   localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_CYC - 1);

   state_e          state, state_d;
   logic [MW-1:0]   mem_cnt, mem_cnt_d;
   logic [FW-1:0]   flush_cnt, flush_cnt_d;
   ctrl_t           q, q_d, dec;
   logic            valid_q, valid_d;
   logic            br_q, br_d;
   logic            jmp_q, jmp_d;
   logic            dec_ldst, dec_jmp, dec_br;
   logic            br_hit;

   ctrl_decode u_decode (
      .mach_code (mach_code),
      .ctrl      (dec),
      .is_ldst   (dec_ldst),
      .is_jmp    (dec_jmp),
      .is_br     (dec_br)
   );

   always_comb begin
      state_d     = state;
      mem_cnt_d   = mem_cnt;
      flush_cnt_d = flush_cnt;
      q_d         = '0;
      valid_d     = 1'b0;
      br_d        = 1'b0;
      jmp_d       = 1'b0;
      in_ready    = (state != ST_MEM);
      br_hit      = (state == ST_RUN) && br_q && br_taken;
      case (state)
         ST_RUN: begin
            // The instruction accepted alongside a taken branch is the first squashed one.
            if (br_hit) begin
               state_d     = ST_FLUSH;
               flush_cnt_d = '0;
               if (in_valid) begin
                  if (FLUSH_CYC == 1) state_d = ST_RUN;
                  else                flush_cnt_d = FW'(1);
               end
            end else if (in_valid) begin
               q_d     = dec;
               valid_d = 1'b1;
               br_d    = dec_br;
               if (dec_ldst && (MEM_LAT > 1)) begin
                  state_d   = ST_MEM;
                  mem_cnt_d = '0;
                  q_d.WenR  = 1'b0;
               end
               if (dec_jmp) begin
                  state_d     = ST_FLUSH;
                  flush_cnt_d = '0;
                  jmp_d       = 1'b1;
               end
            end
         end
         ST_MEM: begin
            if (mem_cnt == MEM_LAST) begin
               state_d   = ST_RUN;
               mem_cnt_d = '0;
            end else begin
               q_d       = q;
               valid_d   = 1'b1;
               q_d.WenD  = 1'b0;
               q_d.WenR  = q.Ldr && (mem_cnt == MEM_PRE);
               mem_cnt_d = mem_cnt + 1'b1;
            end
         end
         ST_FLUSH: begin
            if (in_valid) begin
               if (flush_cnt == FLUSH_LAST) begin
                  state_d     = ST_RUN;
                  flush_cnt_d = '0;
               end else begin
                  flush_cnt_d = flush_cnt + 1'b1;
               end
            end
         end
         default: state_d = ST_RUN;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state     <= ST_RUN;
         mem_cnt   <= '0;
         flush_cnt <= '0;
         q         <= '0;
         valid_q   <= 1'b0;
         br_q      <= 1'b0;
         jmp_q     <= 1'b0;
      end else begin
         state     <= state_d;
         mem_cnt   <= mem_cnt_d;
         flush_cnt <= flush_cnt_d;
         q         <= q_d;
         valid_q   <= valid_d;
         br_q      <= br_d;
         jmp_q     <= jmp_d;
      end
   end

   assign Aluop     = q.Aluop;
   assign Jptr      = q.Jptr;
   assign Ra        = RW'(q.Ra);
   assign Rb        = RW'(q.Rb);
   assign Wd        = RW'(q.Wd);
   assign Imm       = q.Imm;
   assign WenR      = q.WenR;
   assign WenD      = q.WenD;
   assign Ldr       = q.Ldr;
   assign Str       = q.Str;
   assign out_valid = valid_q;
   assign out_is_br = br_q;
   assign redirect  = jmp_q | br_hit;

endmodule

// File: tb/tb_ctrl_pipe.sv
// tb/tb_ctrl_pipe.sv - self-checking bench for ctrl_pipe
module tb_ctrl_pipe;

   localparam int MEM_LAT   = 3;
   localparam int FLUSH_CYC = 2;
   localparam int RW        = 4;

   logic          Clk = 1'b0;
   logic          Reset;
   logic [8:0]    mach_code;
   logic          in_valid;
   logic          in_ready;
   logic          br_taken;
   logic [3:0]    Aluop;
   logic [4:0]    Jptr;
   logic [RW-1:0] Ra, Rb, Wd;
   logic [2:0]    Imm;
   logic          WenR, WenD, Ldr, Str;
   logic          out_valid, out_is_br, redirect;

   typedef struct packed {
      logic [3:0] aluop;
      logic [4:0] jptr;
      logic [3:0] ra;
      logic [3:0] rb;
      logic [3:0] wd;
      logic [2:0] imm;
      logic       wenr;
      logic       wend;
      logic       ldr;
      logic       str;
   } exp_t;

   int total = 0;
   int bad   = 0;

   exp_t m_dec;
   bit   m_valid, m_isbr, m_isjmp;
   int   m_mem, m_sq;

   ctrl_pipe #(.MEM_LAT(MEM_LAT), .FLUSH_CYC(FLUSH_CYC), .RW(RW)) dut (
      .Clk(Clk), .Reset(Reset), .mach_code(mach_code), .in_valid(in_valid),
      .in_ready(in_ready), .br_taken(br_taken), .Aluop(Aluop), .Jptr(Jptr),
      .Ra(Ra), .Rb(Rb), .Wd(Wd), .Imm(Imm), .WenR(WenR), .WenD(WenD),
      .Ldr(Ldr), .Str(Str), .out_valid(out_valid), .out_is_br(out_is_br),
      .redirect(redirect)
   );

   always #5 Clk = ~Clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout want finish");
      $fatal(1);
   end

   function automatic exp_t mk(int aluop, int jptr, int ra, int rb, int wd, int imm,
                               bit wenr, bit wend, bit ldr, bit str);
      exp_t e;
      e.aluop = 4'(aluop); e.jptr = 5'(jptr);
      e.ra = 4'(ra); e.rb = 4'(rb); e.wd = 4'(wd); e.imm = 3'(imm);
      e.wenr = wenr; e.wend = wend; e.ldr = ldr; e.str = str;
      return e;
   endfunction

   function automatic exp_t act();
      exp_t e;
      e = {Aluop, Jptr, Ra, Rb, Wd, Imm, WenR, WenD, Ldr, Str};
      return e;
   endfunction

   function automatic exp_t ref_decode(logic [8:0] c);
      exp_t e;
      e = '0;
      case (c[8:6])
         3'd0: if (!c[5]) e = mk(0, 0, 0, c[1:0], c[4:2], 0, 1, 0, 1, 0);
               else       e = mk(0, 0, c[4:3], c[2:0], 0, 0, 0, 1, 0, 1);
         3'd1: e = mk(8, 0, c[5:3], c[2:0], c[2:0], 0, 1, 0, 0, 0);
         3'd2: if (c[5:4] != 2'b11) e = mk(c[5:4], 0, c[3:2], c[1:0], c[3:2], 0, 1, 0, 0, 0);
               else e = mk((c[3:2] == 2'b10) ? 4 : (c[3:2] == 2'b01) ? 5 : 3,
                           0, c[1:0], c[1:0], c[1:0], 0, 1, 0, 0, 0);
         3'd3: e = mk(9, 0, c[5:3], 0, c[5:3], c[2:0], 0 + 1, 0, 0, 0);
         3'd4: if (c[5]) e = mk(12, c[4:0], 0, 0, 0, 0, 0, 0, 0, 0);
               else      e = mk(1, 0, c[3:2], c[1:0], c[3:2], 0, 0, 0, 0, 0);
         3'd5: e = mk(6, 0, c[5:3], c[2:0], 0, 0, 0, 0, 0, 0);
         3'd6: e = mk(7, 0, c[5:3], c[2:0], 0, 0, 0, 0, 0, 0);
         default: e = mk(10 + c[5], 0, c[4:3], 0, c[4:3], c[2:0], 1, 0, 0, 0);
      endcase
      return e;
   endfunction

   // Expected {fields, out_valid, out_is_br, in_ready, redirect} for the current cycle.
   function automatic logic [31:0] model_out();
      exp_t e;
      logic isbr, rdy, rdr;
      e = '0;
      if (m_valid) begin
         e = m_dec;
         if (m_mem > 0) begin
            e.wenr = m_dec.ldr && (m_mem == 1);
            e.wend = m_dec.str && (m_mem == MEM_LAT);
         end
      end
      isbr = m_valid && m_isbr;
      rdy  = (m_mem == 0);
      rdr  = (m_valid && m_isjmp) || (m_mem == 0 && m_sq == 0 && isbr && br_taken);
      return {e, m_valid, isbr, rdy, rdr};
   endfunction

   task automatic model_step();
      if (Reset) begin
         m_valid = 0; m_isbr = 0; m_isjmp = 0; m_mem = 0; m_sq = 0; m_dec = '0;
      end else if (m_mem > 0) begin
         m_mem--;
         if (m_mem == 0) m_valid = 0;
      end else if (m_sq > 0) begin
         if (in_valid) m_sq--;
         m_valid = 0;
      end else if (m_valid && m_isbr && br_taken) begin
         m_sq    = FLUSH_CYC - (in_valid ? 1 : 0);
         m_valid = 0;
      end else if (in_valid) begin
         m_dec   = ref_decode(mach_code);
         m_valid = 1;
         m_isbr  = (mach_code[8:6] == 3'd5) || (mach_code[8:6] == 3'd6);
         m_isjmp = (mach_code[8:6] == 3'd4) && mach_code[5];
         m_mem   = (mach_code[8:6] == 3'd0 && MEM_LAT > 1) ? MEM_LAT : 0;
         m_sq    = m_isjmp ? FLUSH_CYC : 0;
      end else begin
         m_valid = 0;
      end
   endtask

   task automatic drive(logic [8:0] c, logic v, logic b);
      mach_code = c; in_valid = v; br_taken = b;
      #2;
   endtask

   task automatic tick();
      model_step();
      @(posedge Clk);
      #1;
   endtask

   task automatic test_reset();
      drive(9'b000_0_110_01, 1, 0); tick();
      drive(9'b001_010_101, 1, 0); tick();
      Reset = 1; tick(); tick(); Reset = 0;
      drive(9'b000000000, 0, 0);
      total++; if (act() !== exp_t'(0)) begin bad++; $display("FAIL reset_fields: got %h want 0", act()); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", out_valid); end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", in_ready); end
      total++; if ({out_is_br, redirect} !== 2'b00) begin bad++; $display("FAIL reset_br: got %b want 00", {out_is_br, redirect}); end
      tick();
      total++; if ({WenR, WenD, out_valid} !== 3'b000) begin bad++; $display("FAIL reset_abort: got %b want 000", {WenR, WenD, out_valid}); end
   endtask

   task automatic test_streaming();
      drive(9'b111_0_01_011, 1, 0); tick();
      drive(9'b001_010_101, 1, 0);
      total++; if ({out_valid, act()} !== {1'b1, mk(10, 0, 1, 0, 1, 3, 1, 0, 0, 0)}) begin
         bad++; $display("FAIL stream_addi: got %h want %h", {out_valid, act()}, {1'b1, mk(10, 0, 1, 0, 1, 3, 1, 0, 0, 0)}); end
      tick();
      drive(9'b000000000, 0, 1);
      total++; if ({out_valid, act()} !== {1'b1, mk(8, 0, 2, 5, 5, 0, 1, 0, 0, 0)}) begin
         bad++; $display("FAIL stream_mov: got %h want %h", {out_valid, act()}, {1'b1, mk(8, 0, 2, 5, 5, 0, 1, 0, 0, 0)}); end
      total++; if (redirect !== 1'b0) begin bad++; $display("FAIL stream_no_redirect: got %b want 0", redirect); end
      tick();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stream_bubble: got %b want 0", out_valid); end
   endtask

   task automatic test_load();
      drive(9'b000_0_110_01, 1, 0); tick();
      drive(9'b001_010_101, 1, 0);
      for (int k = 1; k <= 3; k++) begin
         total++; if (act() !== mk(0, 0, 0, 1, 6, 0, k == 3, 0, 1, 0)) begin
            bad++; $display("FAIL load_c%0d: got %h want %h", k, act(), mk(0, 0, 0, 1, 6, 0, k == 3, 0, 1, 0)); end
         total++; if ({in_ready, out_valid} !== 2'b01) begin
            bad++; $display("FAIL load_ready_c%0d: got %b want 01", k, {in_ready, out_valid}); end
         tick();
      end
      total++; if ({in_ready, out_valid} !== 2'b10) begin bad++; $display("FAIL load_done: got %b want 10", {in_ready, out_valid}); end
      tick();
      drive(9'b000000000, 0, 0);
      total++; if (act() !== mk(8, 0, 2, 5, 5, 0, 1, 0, 0, 0)) begin bad++; $display("FAIL load_next: got %h want %h", act(), mk(8, 0, 2, 5, 5, 0, 1, 0, 0, 0)); end
      tick();
   endtask

   task automatic test_store();
      drive(9'b000_1_10_011, 1, 0); tick();
      drive(9'b000000000, 0, 0);
      for (int k = 1; k <= 3; k++) begin
         total++; if ({in_ready, act()} !== {1'b0, mk(0, 0, 2, 3, 0, 0, 0, k == 1, 0, 1)}) begin
            bad++; $display("FAIL store_c%0d: got %h want %h", k, {in_ready, act()}, {1'b0, mk(0, 0, 2, 3, 0, 0, 0, k == 1, 0, 1)}); end
         tick();
      end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL store_done: got %b want 0", out_valid); end
   endtask

   task automatic test_branch();
      drive(9'b110_001_010, 1, 0); tick();
      drive(9'b111_0_01_011, 1, 1);
      total++; if ({redirect, out_is_br, act()} !== {2'b11, mk(7, 0, 1, 2, 0, 0, 0, 0, 0, 0)}) begin
         bad++; $display("FAIL beq_taken: got %h want %h", {redirect, out_is_br, act()}, {2'b11, mk(7, 0, 1, 2, 0, 0, 0, 0, 0, 0)}); end
      tick();
      drive(9'b001_010_101, 1, 1);
      total++; if ({out_valid, redirect, in_ready} !== 3'b001) begin
         bad++; $display("FAIL beq_squash1: got %b want 001", {out_valid, redirect, in_ready}); end
      tick();
      drive(9'b011_101_110, 1, 0);
      total++; if ({out_valid, redirect} !== 2'b00) begin bad++; $display("FAIL beq_squash2: got %b want 00", {out_valid, redirect}); end
      tick();
      drive(9'b000000000, 0, 0);
      total++; if ({out_valid, act()} !== {1'b1, mk(9, 0, 5, 0, 5, 6, 1, 0, 0, 0)}) begin
         bad++; $display("FAIL beq_resume: got %h want %h", {out_valid, act()}, {1'b1, mk(9, 0, 5, 0, 5, 6, 1, 0, 0, 0)}); end
      tick();
   endtask

   task automatic test_jump_reset();
      drive(9'b100_1_10101, 1, 0); tick();
      drive(9'b111_0_01_011, 1, 0);
      total++; if ({out_valid, redirect, act()} !== {2'b11, mk(12, 21, 0, 0, 0, 0, 0, 0, 0, 0)}) begin
         bad++; $display("FAIL jump: got %h want %h", {out_valid, redirect, act()}, {2'b11, mk(12, 21, 0, 0, 0, 0, 0, 0, 0, 0)}); end
      tick();
      drive(9'b001_010_101, 1, 0);
      total++; if ({out_valid, redirect} !== 2'b00) begin bad++; $display("FAIL jump_squash1: got %b want 00", {out_valid, redirect}); end
      Reset = 1; tick(); tick(); Reset = 0;
      drive(9'b111_0_01_011, 1, 0);
      total++; if ({in_ready, out_valid} !== 2'b10) begin bad++; $display("FAIL jump_reset: got %b want 10", {in_ready, out_valid}); end
      tick();
      drive(9'b000000000, 0, 0);
      total++; if ({out_valid, act()} !== {1'b1, mk(10, 0, 1, 0, 1, 3, 1, 0, 0, 0)}) begin
         bad++; $display("FAIL jump_after_reset: got %h want %h", {out_valid, act()}, {1'b1, mk(10, 0, 1, 0, 1, 3, 1, 0, 0, 0)}); end
      tick();
   endtask

   task automatic test_random();
      logic [31:0] got_v, exp_v;
      logic        prev_redir;
      prev_redir = 1'b0;
      for (int i = 0; i < 600; i++) begin
         Reset = ($urandom_range(0, 79) == 0);
         drive(9'($urandom_range(0, 511)), $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)));
         exp_v = model_out();
         got_v = {act(), out_valid, out_is_br, in_ready, redirect};
         total++; if (got_v !== exp_v) begin
            bad++; $display("FAIL random_c%0d: got %h want %h", i, got_v, exp_v); end
         if (prev_redir) begin
            total++; if (redirect !== 1'b0) begin bad++; $display("FAIL random_redirect_twice_c%0d: got %b want 0", i, redirect); end
         end
         prev_redir = redirect;
         tick();
      end
      Reset = 0;
   endtask

   initial begin
      Reset = 1;
      drive(9'b000000000, 0, 0);
      tick(); tick();
      Reset = 0;
      test_reset();
      test_streaming();
      test_load();
      test_store();
      test_branch();
      test_jump_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
